// File: rtl/xcalc_seq.sv
// xcalc_seq: calculator sequencer. Debounced buttons capture operands and the op, start the ALU,
// wait for completion with a timeout and drive the display. Define XCALC_CHAIN_EN for accumulator chaining.
module xcalc_seq #(
  parameter int DEB_CYCLES = 16,
  parameter int TIMEOUT    = 255,
  parameter int NR_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_enter,
  input  logic            btn_clr,
  input  logic [7:0]      sw,
  output logic [NR_W-1:0] alu_first,
  output logic [NR_W-1:0] alu_second,
  output logic [NR_W-1:0] alu_op,
  output logic            alu_start,
  input  logic            alu_done,
  input  logic [7:0]      alu_result,
  output logic [7:0]      disp_bin,
  output logic [1:0]      disp_msg,
  output logic            disp_sgn,
  output logic            disp_we,
  output logic            busy,
  output logic            err
);

  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, WAIT, SHOW, ERR} state_e;
  typedef enum logic [1:0] {
    MSG_NUM = 2'b00,
    MSG_OP  = 2'b01,
    MSG_VAL = 2'b10,
    MSG_ERR = 2'b11
  } msg_e;

  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [NR_W-1:0] OP_SUB = NR_W'(1);
  localparam logic [NR_W-1:0] OP_DIV = NR_W'(3);

  // Index 0 is the enter button, index 1 the clear button.
  logic [1:0]      btn_s1, btn_s2, btn_lvl, btn_lvl_d;
  logic [DCW-1:0]  deb_cnt [2];
  logic [NR_W-1:0] sw_s1, sw_s2;
  logic            enter_p, clr_p;
  logic            unused_sw;

  assign unused_sw = ^sw[7:NR_W];

  // NOTE: state uses non-blocking assignments and an asynchronous clear so every
  // flop reads the pre-edge value of its neighbours and resets without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1    <= '0;
      btn_s2    <= '0;
      btn_lvl   <= '0;
      btn_lvl_d <= '0;
      sw_s1     <= '0;
      sw_s2     <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      btn_s1    <= {btn_clr, btn_enter};
      btn_s2    <= btn_s1;
      sw_s1     <= sw[NR_W-1:0];
      sw_s2     <= sw_s1;
      btn_lvl_d <= btn_lvl;
      for (int i = 0; i < 2; i++) begin
        if (btn_s2[i] == btn_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
          btn_lvl[i] <= btn_s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign enter_p = btn_lvl[0] & ~btn_lvl_d[0];
  assign clr_p   = btn_lvl[1] & ~btn_lvl_d[1];

  state_e          state_q, state_d;
  msg_e            msg_q, msg_d;
  logic [NR_W-1:0] a_q, a_d, b_q, b_d, op_q, op_d;
  logic [7:0]      bin_q, bin_d;
  logic            sgn_q, sgn_d, we_q, we_d;
  logic [TCW-1:0]  tcnt_q, tcnt_d;
`ifdef XCALC_CHAIN_EN
  logic [7:0]      res_q, res_d;
`endif

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    bin_d   = bin_q;
    sgn_d   = sgn_q;
    we_d    = 1'b0;
    tcnt_d  = tcnt_q;
`ifdef XCALC_CHAIN_EN
    res_d   = res_q;
`endif
    if (clr_p) begin
      state_d = GET_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      msg_d   = MSG_VAL;
      we_d    = 1'b1;
    end else begin
      unique case (state_q)
        GET_A: if (enter_p) begin
          a_d     = sw_s2;
          state_d = GET_B;
          msg_d   = MSG_VAL;
          we_d    = 1'b1;
        end
        GET_B: if (enter_p) begin
          b_d     = sw_s2;
          state_d = GET_OP;
          msg_d   = MSG_OP;
          we_d    = 1'b1;
        end
        GET_OP: if (enter_p) begin
          op_d = sw_s2;
          if (sw_s2 > OP_DIV || (sw_s2 == OP_DIV && b_q == '0)) begin
            state_d = ERR;
            msg_d   = MSG_ERR;
            we_d    = 1'b1;
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          tcnt_d  = '0;
          state_d = WAIT;
        end
        WAIT: begin
          tcnt_d = tcnt_q + 1'b1;
          if (alu_done) begin
            state_d = SHOW;
            msg_d   = MSG_NUM;
            we_d    = 1'b1;
`ifdef XCALC_CHAIN_EN
            res_d   = alu_result;
`endif
            if (op_q == OP_SUB && alu_result[7]) begin
              bin_d = 8'd0 - alu_result;
              sgn_d = 1'b1;
            end else begin
              bin_d = alu_result;
              sgn_d = 1'b0;
            end
          end else if (tcnt_d == TCW'(TIMEOUT - 1)) begin
            // Error state is entered exactly TIMEOUT cycles after the start pulse.
            state_d = ERR;
            msg_d   = MSG_ERR;
            we_d    = 1'b1;
          end
        end
        SHOW: if (enter_p) begin
`ifdef XCALC_CHAIN_EN
          if ((op_q == OP_SUB && res_q[7]) || res_q > 8'(2**NR_W - 1)) begin
            state_d = ERR;
            msg_d   = MSG_ERR;
          end else begin
            a_d     = res_q[NR_W-1:0];
            state_d = GET_B;
            msg_d   = MSG_VAL;
          end
`else
          state_d = GET_A;
          msg_d   = MSG_VAL;
`endif
          we_d = 1'b1;
        end
        ERR: ;
        default: state_d = GET_A;
      endcase
    end
    // The sign only accompanies a shown number.
    if (msg_d != MSG_NUM) sgn_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= GET_A;
      msg_q   <= MSG_VAL;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      bin_q   <= '0;
      sgn_q   <= 1'b0;
      we_q    <= 1'b0;
      tcnt_q  <= '0;
`ifdef XCALC_CHAIN_EN
      res_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      bin_q   <= bin_d;
      sgn_q   <= sgn_d;
      we_q    <= we_d;
      tcnt_q  <= tcnt_d;
`ifdef XCALC_CHAIN_EN
      res_q   <= res_d;
`endif
    end
  end

  assign alu_first  = a_q;
  assign alu_second = b_q;
  assign alu_op     = op_q;
  assign alu_start  = (state_q == EXEC);
  assign busy       = (state_q == EXEC) || (state_q == WAIT);
  assign err        = (state_q == ERR);
  assign disp_bin   = bin_q;
  assign disp_msg   = msg_q;
  assign disp_sgn   = sgn_q;
  assign disp_we    = we_q;

endmodule

// File: tb/tb_xcalc_seq.sv
// Self-checking bench for xcalc_seq: a transaction-level model predicts every ALU start and
// display write from the button/switch actions; a compare process checks each strobe against it.
module tb_xcalc_seq;

  localparam int TIMEOUT = 255;

  logic       clk = 1'b0, rst = 1'b0;
  logic       btn_enter = 1'b0, btn_clr = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [3:0] alu_first, alu_second, alu_op;
  logic       alu_start, alu_done = 1'b0;
  logic [7:0] alu_result = 8'h00;
  logic [7:0] disp_bin;
  logic [1:0] disp_msg;
  logic       disp_sgn, disp_we, busy, err;

  xcalc_seq #(.DEB_CYCLES(16), .TIMEOUT(TIMEOUT), .NR_W(4)) dut (
    .clk(clk), .rst(rst), .btn_enter(btn_enter), .btn_clr(btn_clr), .sw(sw),
    .alu_first(alu_first), .alu_second(alu_second), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .disp_bin(disp_bin), .disp_msg(disp_msg),
    .disp_sgn(disp_sgn), .disp_we(disp_we), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed { logic [1:0] msg; logic [7:0] bin; logic sgn; } disp_t;
  typedef struct packed { logic [3:0] a; logic [3:0] b; logic [3:0] op; } start_t;
  typedef enum {P_A, P_B, P_OP, P_RUN, P_SHOW, P_ERR} phase_e;

  disp_t  exp_disp[$];
  start_t exp_start[$];
  phase_e ph = P_A;
  logic [3:0] m_a = 0, m_b = 0, m_op = 0;
  logic [7:0] m_res = 0;
  logic       m_neg = 0;

  task automatic exp_write(input logic [1:0] m, input logic [7:0] b, input logic s);
    disp_t d;
    d.msg = m; d.bin = b; d.sgn = s;
    exp_disp.push_back(d);
  endtask

  task automatic model_enter(input logic [3:0] v);
    start_t s;
    case (ph)
      P_A:  begin m_a = v; exp_write(2'b10, 8'h0, 1'b0); ph = P_B; end
      P_B:  begin m_b = v; exp_write(2'b01, 8'h0, 1'b0); ph = P_OP; end
      P_OP: begin
        m_op = v;
        if (v > 4'd3 || (v == 4'd3 && m_b == 4'd0)) begin
          exp_write(2'b11, 8'h0, 1'b0); ph = P_ERR;
        end else begin
          s.a = m_a; s.b = m_b; s.op = v;
          exp_start.push_back(s); ph = P_RUN;
        end
      end
      P_SHOW: begin
`ifdef XCALC_CHAIN_EN
        if (m_neg || m_res > 8'd15) begin
          exp_write(2'b11, 8'h0, 1'b0); ph = P_ERR;
        end else begin
          m_a = m_res[3:0]; exp_write(2'b10, 8'h0, 1'b0); ph = P_B;
        end
`else
        exp_write(2'b10, 8'h0, 1'b0); ph = P_A;
`endif
      end
      default: ;
    endcase
  endtask

  task automatic model_clr();
    exp_write(2'b10, 8'h0, 1'b0);
    m_a = 0; m_b = 0; m_op = 0; ph = P_A;
  endtask

  task automatic model_result(input logic [7:0] r);
    m_res = r;
    m_neg = (m_op == 4'd1) && r[7];
    if (m_neg) exp_write(2'b00, 8'd0 - r, 1'b1);
    else       exp_write(2'b00, r, 1'b0);
    ph = P_SHOW;
  endtask

  // ---------------- ALU responder ----------------
  bit         resp_en = 0, resp_expect = 0;
  int         resp_delay = 4;
  logic [7:0] resp_result = 8'h00;
  int         done_cyc = 0, start_cyc = 0, n_starts = 0;

  always @(negedge clk) begin
    if (rst === 1'b1 && alu_start === 1'b1 && resp_en) begin
      repeat (resp_delay) @(posedge clk);
      #1;
      if (resp_expect) model_result(resp_result);
      done_cyc   = cyc;
      alu_result = resp_result;
      alu_done   = 1'b1;
      @(posedge clk);
      #1;
      alu_done = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    disp_t  e;
    start_t s;
    if (rst === 1'b1) begin
      if (alu_start === 1'b1) begin
        n_starts++;
        start_cyc = cyc;
        check("alu_start_expected", exp_start.size() != 0, 1);
        if (exp_start.size() != 0) begin
          s = exp_start.pop_front();
          check("alu_operands", {alu_first, alu_second, alu_op}, {s.a, s.b, s.op});
        end
      end
      if (disp_we === 1'b1) begin
        check("disp_we_expected", exp_disp.size() != 0, 1);
        if (exp_disp.size() != 0) begin
          e = exp_disp.pop_front();
          check("disp_msg", disp_msg, e.msg);
          check("disp_sgn", disp_sgn, e.sgn);
          check("err_vs_msg", err, e.msg == 2'b11);
          if (e.msg == 2'b00) begin
            check("disp_bin", disp_bin, e.bin);
            check("done_to_we_latency", cyc - done_cyc, 1);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit ent, input bit clr, input logic [3:0] v);
    sw = {4'h0, v};
    tick(4);
    btn_enter = ent; btn_clr = clr;
    tick(25);
    btn_enter = 1'b0; btn_clr = 1'b0;
    tick(25);
  endtask

  task automatic enter(input logic [3:0] v);
    model_enter(v);
    press(1'b1, 1'b0, v);
  endtask

  task automatic clear();
    model_clr();
    press(1'b0, 1'b1, 4'h0);
  endtask

  task automatic arm(input int d, input logic [7:0] r, input bit expect_it);
    resp_en = 1; resp_delay = d; resp_result = r; resp_expect = expect_it;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_operands"}, {alu_first, alu_second, alu_op}, 12'h000);
    check({tag, "_start"}, alu_start, 0);
    check({tag, "_disp"}, {disp_bin, disp_msg, disp_sgn, disp_we}, {8'h00, 2'b10, 1'b0, 1'b0});
    check({tag, "_busy_err"}, {busy, err}, 2'b00);
  endtask

  int starts_before;

  initial begin
    // Reset values while rst is held low.
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    tick(3);

    // Bouncy enter: five 3-cycle glitches then a stable press must capture A once.
    model_enter(4'd5);
    sw = 8'd5;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      btn_enter = 1'b1; tick(3);
      btn_enter = 1'b0; tick(3);
    end
    btn_enter = 1'b1; tick(20);
    btn_enter = 1'b0; tick(25);
    check("bounce_single_capture", {exp_disp.size(), alu_first}, {32'd0, 4'd5});

    // Add 5 + 3, ALU answers after 4 cycles with 8.
    enter(4'd3);
    arm(4, 8'd8, 1);
    enter(4'd0);
    resp_en = 0;
    check("add_start_count", n_starts, 1);
    check("add_operands_held", {alu_first, alu_second, alu_op}, {4'd5, 4'd3, 4'd0});
    check("add_display", {disp_bin, disp_msg, disp_sgn}, {8'd8, 2'b00, 1'b0});
    check("add_idle", {busy, err}, 2'b00);
    enter(4'd0);   // leave SHOW
    clear();

    // Sub 2 - 7 = 0xFB, shown as magnitude 5 with sign.
    enter(4'd2);
    enter(4'd7);
    arm(2, 8'hFB, 1);
    enter(4'd1);
    resp_en = 0;
    check("sub_display", {disp_bin, disp_msg, disp_sgn}, {8'd5, 2'b00, 1'b1});
    clear();

    // Divide by zero and an invalid op both go to ERR without starting the ALU.
    starts_before = n_starts;
    enter(4'd9);
    enter(4'd0);
    enter(4'd3);
    check("div0_err", {err, disp_msg, busy}, {1'b1, 2'b11, 1'b0});
    clear();
    check("clr_from_err", {err, disp_msg}, {1'b0, 2'b10});
    enter(4'd4);
    enter(4'd2);
    enter(4'd6);
    check("badop_err", {err, disp_msg}, {1'b1, 2'b11});
    enter(4'd5);   // ignored in ERR
    check("err_ignores_enter", {err, disp_msg}, {1'b1, 2'b11});
    check("no_start_on_error", n_starts, starts_before);
    clear();

    // Timeout: no alu_done, ERR exactly TIMEOUT cycles after alu_start.
    enter(4'd1);
    enter(4'd1);
    enter(4'd2);
    check("busy_in_wait", busy, 1);
    exp_write(2'b11, 8'h0, 1'b0);
    ph = P_ERR;
    for (int i = 0; i < 400 && err !== 1'b1; i++) @(negedge clk);
    check("timeout_reached", err, 1);
    check("timeout_cycles", cyc - start_cyc, TIMEOUT);
    tick(1);
    clear();

    // Done on the last wait cycle wins over the timeout.
    enter(4'd6);
    enter(4'd7);
    arm(TIMEOUT - 1, 8'd13, 1);
    enter(4'd0);
    for (int i = 0; i < 400 && disp_msg !== 2'b00; i++) @(negedge clk);
    resp_en = 0;
    check("done_wins_boundary", {err, disp_msg, disp_bin}, {1'b0, 2'b00, 8'd13});
    tick(1);
    clear();

    // Same-cycle enter and clear in GET_B: clear wins, operands zeroed, next enter captures A.
    enter(4'd9);
    model_clr();
    press(1'b1, 1'b1, 4'd4);
    check("clr_wins_operands", {alu_first, alu_second, alu_op}, 12'h000);
    check("clr_wins_msg", disp_msg, 2'b10);
    enter(4'd4);
    check("after_clr_captures_a", {alu_first, alu_second}, {4'd4, 4'd0});
    clear();

    // Reset in the middle of WAIT; the late alu_done must not write the display.
    enter(4'd3);
    enter(4'd4);
    arm(60, 8'd7, 0);
    enter(4'd0);
    check("busy_before_reset", busy, 1);
    rst = 1'b0;
    #2;
    check_reset_outputs("midwait_reset");
    ph = P_A; m_a = 0; m_b = 0; m_op = 0;
    tick(1);
    rst = 1'b1;
    tick(60);
    resp_en = 0;
    check("late_done_ignored", {disp_bin, disp_msg, busy, err}, {8'h00, 2'b10, 1'b0, 1'b0});

    check("all_display_writes_seen", exp_disp.size(), 0);
    check("all_starts_seen", exp_start.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
